// File: rtl/msg_protocol_pkg.sv
// Shared framing definitions for serial_msg_transmitter and serial_msg_receiver:
// FSM state encoding, default header strings/lengths and header byte selection.
package msg_protocol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_SEND,
    HDR_WAIT,
    PL_REQ,
    PL_SEND,
    PL_WAIT,
    DONE
  } msg_state_e;

  // Headers are right-justified in 64 bits; the first character is the most significant used byte.
  localparam logic [63:0] DEF_PARTICLE_HDR     = {24'h0, "ABCDE"};
  localparam int          DEF_PARTICLE_HDR_LEN = 5;
  localparam logic [63:0] DEF_MAP_HDR          = {24'h0, "FGHIJ"};
  localparam int          DEF_MAP_HDR_LEN      = 5;
  localparam int          DEF_PARTICLE_PL_LEN  = 8;
  localparam int          DEF_MAP_PL_LEN       = 16;

  function automatic logic [7:0] hdr_byte(input logic [63:0] hdr,
                                          input logic [7:0]  last,
                                          input logic [7:0]  k);
    return 8'(hdr >> (8 * (last - k)));
  endfunction

endpackage

// File: rtl/msg_xor_checksum.sv
// Running XOR of accepted payload bytes; used by serial_msg_transmitter
// only when MSG_TX_CHECKSUM_EN is defined.
module msg_xor_checksum (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] checksum
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      checksum <= 8'h00;
    else if (clear)
      checksum <= 8'h00;
    else if (enable)
      checksum <= checksum ^ data;
  end

endmodule

// File: rtl/serial_msg_transmitter.sv
// Frames particle/map messages (header string + payload) for a byte-wide serial_tx.
// Optional trailing XOR checksum byte when MSG_TX_CHECKSUM_EN is defined.
module serial_msg_transmitter
  import msg_protocol_pkg::*;
#(
  parameter logic [63:0] START_PARTICLE_MESSAGE             = DEF_PARTICLE_HDR,
  parameter int          START_PARTICLE_MESSAGE_LENGTH_BYTE = DEF_PARTICLE_HDR_LEN,
  parameter logic [63:0] START_MAP_MESSAGE                  = DEF_MAP_HDR,
  parameter int          START_MAP_MESSAGE_LENGTH_BYTE      = DEF_MAP_HDR_LEN,
  parameter int          PARTICLE_MESSAGE_LENGTH            = DEF_PARTICLE_PL_LEN,
  parameter int          MAP_MESSAGE_LENGTH                 = DEF_MAP_PL_LEN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send_particle,
  input  logic       send_map,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_done,
  output logic       busy,
  output logic       msg_done
);

  localparam logic [7:0] PART_HDR_LAST = 8'(START_PARTICLE_MESSAGE_LENGTH_BYTE - 1);
  localparam logic [7:0] MAP_HDR_LAST  = 8'(START_MAP_MESSAGE_LENGTH_BYTE - 1);
  localparam logic [7:0] PART_PL_LEN   = 8'(PARTICLE_MESSAGE_LENGTH);
  localparam logic [7:0] MAP_PL_LEN    = 8'(MAP_MESSAGE_LENGTH);

  msg_state_e  state, state_next;
  logic        is_map;
  logic [7:0]  hdr_cnt;
  logic [7:0]  pl_cnt;
  logic [7:0]  pl_byte;
  logic [63:0] hdr_vec;
  logic [7:0]  hdr_last;
  logic [7:0]  pl_len;
  logic [7:0]  pl_tx_byte;
  logic        start_req;
  logic        handshake;
  logic        payload_left;

  assign start_req    = send_particle | send_map;
  assign handshake    = (state == PL_REQ) && data_in_valid;
  assign hdr_vec      = is_map ? START_MAP_MESSAGE : START_PARTICLE_MESSAGE;
  assign hdr_last     = is_map ? MAP_HDR_LAST : PART_HDR_LAST;
  assign pl_len       = is_map ? MAP_PL_LEN : PART_PL_LEN;
  assign payload_left = pl_cnt < pl_len;

`ifdef MSG_TX_CHECKSUM_EN
  logic       csum_phase;
  logic [7:0] csum;

  msg_xor_checksum u_checksum (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state == IDLE && start_req),
    .enable   (handshake),
    .data     (data_in),
    .checksum (csum)
  );

  assign pl_tx_byte = csum_phase ? csum : pl_byte;
`else
  assign pl_tx_byte = pl_byte;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      is_map  <= 1'b0;
      hdr_cnt <= 8'h00;
      pl_cnt  <= 8'h00;
      pl_byte <= 8'h00;
`ifdef MSG_TX_CHECKSUM_EN
      csum_phase <= 1'b0;
`endif
    end else begin
      state <= state_next;
      // send_particle wins a simultaneous request; the map request is simply dropped.
      if (state == IDLE && start_req) begin
        is_map  <= ~send_particle;
        hdr_cnt <= 8'h00;
        pl_cnt  <= 8'h00;
`ifdef MSG_TX_CHECKSUM_EN
        csum_phase <= 1'b0;
`endif
      end
      if (state == HDR_WAIT && tx_done && hdr_cnt != hdr_last)
        hdr_cnt <= hdr_cnt + 8'd1;
      if (handshake) begin
        pl_byte <= data_in;
        pl_cnt  <= pl_cnt + 8'd1;
      end
`ifdef MSG_TX_CHECKSUM_EN
      if (state == PL_WAIT && tx_done && !payload_left)
        csum_phase <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;
    data_in_ready = 1'b0;
    busy          = 1'b1;
    msg_done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_req)
          state_next = HDR_SEND;
      end
      HDR_SEND: begin
        tx_data       = hdr_byte(hdr_vec, hdr_last, hdr_cnt);
        tx_data_valid = 1'b1;
        state_next    = HDR_WAIT;
      end
      HDR_WAIT: begin
        tx_data = hdr_byte(hdr_vec, hdr_last, hdr_cnt);
        if (tx_done)
          state_next = (hdr_cnt == hdr_last) ? PL_REQ : HDR_SEND;
      end
      PL_REQ: begin
        data_in_ready = 1'b1;
        if (data_in_valid)
          state_next = PL_SEND;
      end
      PL_SEND: begin
        tx_data       = pl_tx_byte;
        tx_data_valid = 1'b1;
        state_next    = PL_WAIT;
      end
      PL_WAIT: begin
        tx_data = pl_tx_byte;
        if (tx_done) begin
          if (payload_left)
            state_next = PL_REQ;
          else
`ifdef MSG_TX_CHECKSUM_EN
            state_next = csum_phase ? DONE : PL_SEND;
`else
            state_next = DONE;
`endif
        end
      end
      DONE: begin
        msg_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_msg_transmitter.sv
// Self-checking bench for serial_msg_transmitter: randomized payloads and serial_tx
// latencies compared against a queue-based message model (honours MSG_TX_CHECKSUM_EN).
module tb_serial_msg_transmitter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       send_particle = 1'b0;
  logic       send_map = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       resp_done = 1'b0;
  logic       spur_done = 1'b0;
  logic       data_in_ready, tx_data_valid, busy, msg_done, tx_done;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  int tx_delay = 10;
  int valid_count = 0;
  int done_count = 0;
  bit src_stall_en = 1'b0;
  logic [7:0] src_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  assign tx_done = resp_done | spur_done;

  serial_msg_transmitter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .send_particle (send_particle),
    .send_map      (send_map),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_done       (tx_done),
    .busy          (busy),
    .msg_done      (msg_done)
  );

  always #5 clk = ~clk;

  // Upstream source: offers the head of src_q, optionally with random gaps.
  initial forever begin
    @(negedge clk);
    if (src_q.size() > 0 && (!src_stall_en || $urandom_range(0, 3) != 0)) begin
      data_in       = src_q[0];
      data_in_valid = 1'b1;
    end else begin
      data_in       = 8'($urandom);
      data_in_valid = 1'b0;
    end
    if (data_in_ready && data_in_valid)
      void'(src_q.pop_front());
  end

  // serial_tx model: records each started byte, checks it holds, answers after tx_delay cycles.
  initial forever begin
    logic [7:0] cap;
    bit aborted, unstable;
    @(negedge clk);
    resp_done = 1'b0;
    if (tx_data_valid === 1'b1) begin
      valid_count++;
      cap = tx_data;
      rx_q.push_back(cap);
      aborted  = 1'b0;
      unstable = 1'b0;
      for (int i = 0; i < tx_delay; i++) begin
        @(negedge clk);
        if (!reset_n) begin
          aborted = 1'b1;
          break;
        end
        if (tx_data !== cap || tx_data_valid !== 1'b0)
          unstable = 1'b1;
      end
      if (!aborted) begin
        checks++;
        if (unstable) begin
          errors++;
          $display("[TB] FAIL tx_hold: tx_data left 0x%02h or valid repeated before tx_done", cap);
        end
        resp_done = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (msg_done === 1'b1)
      done_count++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: header string, then payload, then optional XOR of the payload.
  function automatic void build_expected(input bit is_map);
    string hdr;
    logic [7:0] x;
    hdr = is_map ? "FGHIJ" : "ABCDE";
    exp_q.delete();
    for (int i = 0; i < hdr.len(); i++)
      exp_q.push_back(hdr[i]);
    x = 8'h00;
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      x ^= pay_q[i];
    end
`ifdef MSG_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  task automatic load_random(input int n);
    logic [7:0] b;
    pay_q.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      pay_q.push_back(b);
      src_q.push_back(b);
    end
  endtask

  task automatic pulse_req(input bit p, input bit m);
    @(negedge clk); #1;
    send_particle = p;
    send_map      = m;
    @(negedge clk); #1;
    send_particle = 1'b0;
    send_map      = 1'b0;
  endtask

  task automatic wait_done(input int start_count, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (done_count != start_count) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({tx_data, tx_data_valid, data_in_ready, busy, msg_done} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got data=%h v=%b rdy=%b busy=%b done=%b, expected all 0",
               tx_data, tx_data_valid, data_in_ready, busy, msg_done);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid_count != 0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy=%b pulses=%0d, expected 0 and 0", busy, valid_count);
    end
  endtask

  task automatic test_particle_basic();
    int vb, db;
    bit ok;
    tx_delay = 10;
    src_stall_en = 1'b0;
    pay_q.delete();
    for (int i = 1; i <= 8; i++) begin
      pay_q.push_back(8'(i));
      src_q.push_back(8'(i));
    end
    build_expected(1'b0);
    rx_q.delete();
    vb = valid_count;
    db = done_count;
    pulse_req(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL particle_busy: busy=%b, expected 1", busy);
    end
    wait_done(db, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL particle_timeout: msg_done not seen, expected within budget");
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL particle_len: got %0d bytes, expected %0d", rx_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL particle_byte%0d: got 0x%02h, expected 0x%02h", i, rx_q[i], exp_q[i]);
      end
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (done_count - db != 1 || busy !== 1'b0 || valid_count - vb != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL particle_end: done=%0d busy=%b pulses=%0d, expected 1, 0, %0d",
               done_count - db, busy, valid_count - vb, exp_q.size());
    end
  endtask

  task automatic test_priority();
    int vb, db;
    bit ok;
    tx_delay = 3;
    src_stall_en = 1'b1;
    load_random(8);
    build_expected(1'b0);
    rx_q.delete();
    vb = valid_count;
    db = done_count;
    pulse_req(1'b1, 1'b1);
    wait_done(db, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL priority_timeout: msg_done not seen, expected within budget");
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL priority_len: got %0d bytes, expected %0d", rx_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL priority_byte%0d: got 0x%02h, expected 0x%02h", i, rx_q[i], exp_q[i]);
      end
    end
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid_count - vb != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL priority_map_lost: busy=%b pulses=%0d, expected 0 and %0d",
               busy, valid_count - vb, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int vb, db;
    bit ok, reached, bad;
    tx_delay = 2;
    src_stall_en = 1'b0;
    pay_q.delete();
    rx_q.delete();
    db = done_count;
    pulse_req(1'b0, 1'b1);
    reached = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (data_in_ready === 1'b1) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("[TB] FAIL stall_reach: data_in_ready never rose, expected 1 after header");
    end
    vb = valid_count;
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (data_in_ready !== 1'b1 || busy !== 1'b1)
        bad = 1'b1;
    end
    checks++;
    if (bad || valid_count != vb) begin
      errors++;
      $display("[TB] FAIL stall_hold: ready/busy dropped=%b pulses=%0d, expected 0 and 0",
               bad, valid_count - vb);
    end
    load_random(16);
    build_expected(1'b1);
    wait_done(db, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL stall_len: done=%b bytes=%0d, expected 1 and %0d", ok, rx_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL stall_byte%0d: got 0x%02h, expected 0x%02h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int vb, db;
    bit ok, reached;
    tx_delay = 10;
    src_stall_en = 1'b0;
    load_random(8);
    vb = valid_count;
    pulse_req(1'b1, 1'b0);
    reached = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (valid_count - vb == 4) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("[TB] FAIL rstmid_reach: header byte 3 not started, pulses=%0d expected 4", valid_count - vb);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_data_valid, data_in_ready, busy, msg_done} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs: got data=%h v=%b rdy=%b busy=%b done=%b, expected all 0",
               tx_data, tx_data_valid, data_in_ready, busy, msg_done);
    end
    src_q.delete();
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_no_resume: busy=%b, expected 0", busy);
    end
    load_random(16);
    build_expected(1'b1);
    rx_q.delete();
    db = done_count;
    pulse_req(1'b0, 1'b1);
    wait_done(db, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL rstmid_len: done=%b bytes=%0d, expected 1 and %0d", ok, rx_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rstmid_byte%0d: got 0x%02h, expected 0x%02h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_spurious();
    int vb, db;
    bit ok;
    tx_delay = 4;
    src_stall_en = 1'b1;
    vb = valid_count;
    @(negedge clk); #1;
    spur_done = 1'b1;
    @(negedge clk); #1;
    spur_done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid_count != vb) begin
      errors++;
      $display("[TB] FAIL spurious_done: busy=%b pulses=%0d, expected 0 and 0", busy, valid_count - vb);
    end
    load_random(8);
    build_expected(1'b0);
    rx_q.delete();
    db = done_count;
    pulse_req(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    send_map = 1'b1;
    @(negedge clk); #1;
    send_map = 1'b0;
    wait_done(db, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL busy_req_len: done=%b bytes=%0d, expected 1 and %0d", ok, rx_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL busy_req_byte%0d: got 0x%02h, expected 0x%02h", i, rx_q[i], exp_q[i]);
      end
    end
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid_count - vb != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL busy_req_ignored: busy=%b pulses=%0d, expected 0 and %0d",
               busy, valid_count - vb, exp_q.size());
    end
  endtask

`ifdef MSG_TX_CHECKSUM_EN
  task automatic test_checksum();
    int db;
    bit ok;
    tx_delay = 2;
    src_stall_en = 1'b0;
    pay_q.delete();
    for (int i = 0; i < 15; i++) begin
      pay_q.push_back(8'h5A);
      src_q.push_back(8'h5A);
    end
    pay_q.push_back(8'hFF);
    src_q.push_back(8'hFF);
    build_expected(1'b1);
    rx_q.delete();
    db = done_count;
    pulse_req(1'b0, 1'b1);
    wait_done(db, ok);
    checks++;
    if (!ok || rx_q.size() != 22 || rx_q[rx_q.size()-1] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL checksum_byte: done=%b bytes=%0d last=0x%02h, expected 1, 22, 0xa5",
               ok, rx_q.size(), (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int vb, db;
    bit ok, is_map;
    src_stall_en = 1'b1;
    for (int m = 0; m < 6; m++) begin
      is_map   = 1'($urandom_range(0, 1));
      tx_delay = $urandom_range(1, 6);
      load_random(is_map ? 16 : 8);
      build_expected(is_map);
      rx_q.delete();
      vb = valid_count;
      db = done_count;
      pulse_req(!is_map, is_map);
      wait_done(db, ok);
      checks++;
      if (!ok || rx_q.size() != exp_q.size() || valid_count - vb != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL b2b%0d_len: done=%b bytes=%0d pulses=%0d, expected 1, %0d, %0d",
                 m, ok, rx_q.size(), valid_count - vb, exp_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL b2b%0d_byte%0d: got 0x%02h, expected 0x%02h", m, i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_particle_basic();
    test_priority();
    test_stall();
    test_reset_mid();
    test_spurious();
`ifdef MSG_TX_CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
